// File: rtl/single_cycle_processor.sv
`timescale 1ns/1ps
// Single-cycle RV32I core: fetch, decode, execute and write back within one clock.
// Optional macro HALT_ON_ILLEGAL_EN: an unrecognized opcode freezes the PC until reset.
module single_cycle_processor #(
  parameter int size = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     instruction,
  input  logic [size-1:0] Data_in,
  output logic [size-1:0] Data_out,
  output logic [size-1:0] Addr_out,
  output logic [size-1:0] PC_Addr,
  output logic [2:0]      Mem_type_sel,
  output logic            Mem_write
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_REG    = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_e;

  function automatic alu_op_e alu_dec(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic logic [size-1:0] alu(input alu_op_e op,
                                          input logic signed [size-1:0] a,
                                          input logic signed [size-1:0] b);
    case (op)
      ALU_SUB:  return a - b;
      ALU_SLL:  return a << b[4:0];
      ALU_SLT:  return {{(size-1){1'b0}}, (a < b)};
      ALU_SLTU: return {{(size-1){1'b0}}, ($unsigned(a) < $unsigned(b))};
      ALU_XOR:  return a ^ b;
      ALU_SRL:  return $unsigned(a) >> b[4:0];
      ALU_SRA:  return a >>> b[4:0];
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      default:  return a + b;
    endcase
  endfunction

  logic [size-1:0] pc_q, pc_d;
  logic [size-1:0] rf_q [32];
  logic [size-1:0] rf_d [32];
  logic            halted_q;

  logic [6:0] opcode;
  logic [4:0] rd, rs1_idx, rs2_idx;
  logic [2:0] funct3;
  assign opcode  = instruction[6:0];
  assign rd      = instruction[11:7];
  assign funct3  = instruction[14:12];
  assign rs1_idx = instruction[19:15];
  assign rs2_idx = instruction[24:20];

  logic [size-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign imm_i = {{(size-12){instruction[31]}}, instruction[31:20]};
  assign imm_s = {{(size-12){instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign imm_b = {{(size-12){instruction[31]}}, instruction[7], instruction[30:25],
                  instruction[11:8], 1'b0};
  assign imm_u = {instruction[31:12], 12'b0};
  assign imm_j = {{(size-20){instruction[31]}}, instruction[19:12], instruction[20],
                  instruction[30:21], 1'b0};

  logic [size-1:0]        rs1_val, rs2_val, pc_plus4;
  logic signed [size-1:0] rs1_s, rs2_s;
  assign rs1_val  = (rs1_idx == 5'd0) ? '0 : rf_q[rs1_idx];
  assign rs2_val  = (rs2_idx == 5'd0) ? '0 : rf_q[rs2_idx];
  assign rs1_s    = rs1_val;
  assign rs2_s    = rs2_val;
  assign pc_plus4 = pc_q + 32'd4;

  logic            br_taken;
  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = (rs1_val == rs2_val);
      3'b001:  br_taken = (rs1_val != rs2_val);
      3'b100:  br_taken = (rs1_s < rs2_s);
      3'b101:  br_taken = !(rs1_s < rs2_s);
      3'b110:  br_taken = (rs1_val < rs2_val);
      3'b111:  br_taken = !(rs1_val < rs2_val);
      default: br_taken = 1'b0;
    endcase
  end

  logic [size-1:0] alu_a, alu_b, alu_y, wb_data;
  alu_op_e         alu_op;
  wb_sel_e         wb_sel;
  logic            rd_we, rf_we, is_store, is_mem, is_jump, is_branch;
`ifdef HALT_ON_ILLEGAL_EN
  logic            illegal;
`endif

  // Decode: the ALU also forms jump/branch targets and memory addresses.
  always_comb begin
    alu_a     = rs1_val;
    alu_b     = imm_i;
    alu_op    = ALU_ADD;
    wb_sel    = WB_ALU;
    rd_we     = 1'b0;
    is_store  = 1'b0;
    is_mem    = 1'b0;
    is_jump   = 1'b0;
    is_branch = 1'b0;
`ifdef HALT_ON_ILLEGAL_EN
    illegal   = 1'b0;
`endif
    case (opcode)
      OPC_LUI:    begin alu_a = '0;   alu_b = imm_u; rd_we = 1'b1; end
      OPC_AUIPC:  begin alu_a = pc_q; alu_b = imm_u; rd_we = 1'b1; end
      OPC_JAL:    begin alu_a = pc_q; alu_b = imm_j; rd_we = 1'b1; wb_sel = WB_PC4; is_jump = 1'b1; end
      OPC_JALR:   begin rd_we = 1'b1; wb_sel = WB_PC4; is_jump = 1'b1; end
      OPC_BRANCH: begin alu_a = pc_q; alu_b = imm_b; is_branch = 1'b1; end
      OPC_LOAD:   begin rd_we = 1'b1; wb_sel = WB_MEM; is_mem = 1'b1; end
      OPC_STORE:  begin alu_b = imm_s; is_store = 1'b1; is_mem = 1'b1; end
      OPC_IMM:    begin
        rd_we  = 1'b1;
        alu_op = alu_dec(funct3, (funct3 == 3'b101) && instruction[30]);
      end
      OPC_REG:    begin
        rd_we  = 1'b1;
        alu_b  = rs2_val;
        alu_op = alu_dec(funct3, instruction[30]);
      end
      OPC_FENCE, OPC_SYSTEM: begin end
      default: begin
`ifdef HALT_ON_ILLEGAL_EN
        illegal = 1'b1;
`endif
      end
    endcase
  end

  assign alu_y = alu(alu_op, alu_a, alu_b);
  assign rf_we = rd_we && !halted_q;

  always_comb begin
    pc_d = pc_plus4;
    if (is_jump)
      pc_d = {alu_y[size-1:1], 1'b0};
    else if (is_branch && br_taken)
      pc_d = alu_y;
`ifdef HALT_ON_ILLEGAL_EN
    if (halted_q || illegal)
      pc_d = pc_q;
`endif
    case (wb_sel)
      WB_MEM:  wb_data = Data_in;
      WB_PC4:  wb_data = pc_plus4;
      default: wb_data = alu_y;
    endcase
    rf_d = rf_q;
    if (rf_we && (rd != 5'd0))
      rf_d[rd] = wb_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= '0;
      for (int i = 0; i < 32; i++)
        rf_q[i] <= '0;
    end else begin
      pc_q <= pc_d;
      rf_q <= rf_d;
    end
  end

`ifdef HALT_ON_ILLEGAL_EN
  logic halted_d;
  assign halted_d = halted_q || illegal;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      halted_q <= 1'b0;
    else
      halted_q <= halted_d;
  end
`else
  assign halted_q = 1'b0;
`endif

  assign Data_out     = rs2_val;
  assign Addr_out     = alu_y;
  assign PC_Addr      = reset ? {2'b00, pc_q[size-1:2]} : '0;
  assign Mem_type_sel = is_mem ? funct3 : 3'b010;
  assign Mem_write    = is_store && reset && !halted_q;

endmodule

// File: tb/tb_single_cycle_processor.sv
`timescale 1ns/1ps
// Bench for single_cycle_processor: directed vector table, hand-written corner sequences,
// then random instructions checked against an instruction-level reference model.
module tb_single_cycle_processor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction, Data_in;
  logic [31:0] Data_out, Addr_out, PC_Addr;
  logic [2:0]  Mem_type_sel;
  logic        Mem_write;

  single_cycle_processor dut (
    .clk(clk), .reset(reset), .instruction(instruction), .Data_in(Data_in),
    .Data_out(Data_out), .Addr_out(Addr_out), .PC_Addr(PC_Addr),
    .Mem_type_sel(Mem_type_sel), .Mem_write(Mem_write)
  );

  always #50 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rd, op};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction

  // Register values are observed through Data_out (raw rs2) without clocking.
  task automatic probe(input logic [4:0] n, input logic [31:0] exp);
    instruction = enc_s(12'h000, n, 5'd0, 3'd2);
    #1;
    chk($sformatf("x%0d", n), Data_out, exp);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    #2 reset = 1'b1;
  endtask

  task automatic hstep(input logic [31:0] ins);
    @(negedge clk);
    instruction = ins;
    Data_in = 32'h0;
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_rf [32];
  logic [31:0] m_pc;
  bit          m_halted;

  logic [31:0] e_pa, e_addr, e_dout, n_pc, n_val;
  logic [2:0]  e_mts;
  logic        e_mw, e_mem, e_store, n_we, n_halt;
  logic [4:0]  n_rd;

  task automatic model_reset();
    m_pc = 32'h0;
    m_halted = 1'b0;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
  endtask

  function automatic logic [31:0] ref_alu(input logic [2:0] f3, input bit alt,
                                          input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    case (f3)
      3'd0: return alt ? a - b : a + b;
      3'd1: return a << sh;
      3'd2: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return (a >> sh) | ((alt && a[31]) ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  task automatic model_eval(input logic [31:0] ins, input logic [31:0] din);
    logic [31:0] a, b, ii, si, bi, ui, ji;
    logic [2:0]  f3;
    bit          tk;
    f3 = ins[14:12];
    a  = m_rf[ins[19:15]];
    b  = m_rf[ins[24:20]];
    ii = 32'($signed(ins[31:20]));
    si = 32'($signed({ins[31:25], ins[11:7]}));
    bi = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
    ui = {ins[31:12], 12'h000};
    ji = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
    e_pa = m_pc >> 2; e_mts = 3'd2; e_mw = 1'b0; e_mem = 1'b0; e_store = 1'b0;
    e_addr = 32'h0; e_dout = 32'h0;
    n_pc = m_pc + 32'd4; n_we = 1'b0; n_val = 32'h0; n_rd = ins[11:7]; n_halt = m_halted;
    case (ins[6:0])
      7'h37: begin n_we = 1'b1; n_val = ui; end
      7'h17: begin n_we = 1'b1; n_val = m_pc + ui; end
      7'h6F: begin n_we = 1'b1; n_val = m_pc + 32'd4; n_pc = m_pc + ji; end
      7'h67: begin n_we = 1'b1; n_val = m_pc + 32'd4; n_pc = (a + ii) & 32'hFFFF_FFFE; end
      7'h63: begin
        case (f3)
          3'd0: tk = (a == b);
          3'd1: tk = (a != b);
          3'd4: tk = (int'(a) < int'(b));
          3'd5: tk = (int'(a) >= int'(b));
          3'd6: tk = (a < b);
          3'd7: tk = (a >= b);
          default: tk = 1'b0;
        endcase
        if (tk) n_pc = m_pc + bi;
      end
      7'h03: begin n_we = 1'b1; n_val = din; e_mts = f3; e_mem = 1'b1; e_addr = a + ii; end
      7'h23: begin
        e_mw = 1'b1; e_mts = f3; e_mem = 1'b1; e_store = 1'b1;
        e_addr = a + si; e_dout = b;
      end
      7'h13: begin n_we = 1'b1; n_val = ref_alu(f3, (f3 == 3'd5) && ins[30], a, ii); end
      7'h33: begin n_we = 1'b1; n_val = ref_alu(f3, ins[30], a, b); end
      7'h0F, 7'h73: begin end
      default: begin
`ifdef HALT_ON_ILLEGAL_EN
        n_halt = 1'b1;
`endif
      end
    endcase
    if (n_halt) begin
      n_pc = m_pc; n_we = 1'b0; e_mw = 1'b0;
    end
  endtask

  task automatic rstep(input int k, input logic [31:0] ins, input logic [31:0] din);
    @(negedge clk);
    instruction = ins;
    Data_in = din;
    model_eval(ins, din);
    #1;
    chk($sformatf("r%0d_pc_addr", k), PC_Addr, e_pa);
    chk($sformatf("r%0d_mem_write", k), {31'h0, Mem_write}, {31'h0, e_mw});
    chk($sformatf("r%0d_mem_type", k), {29'h0, Mem_type_sel}, {29'h0, e_mts});
    if (e_mem) chk($sformatf("r%0d_addr", k), Addr_out, e_addr);
    if (e_store) chk($sformatf("r%0d_dout", k), Data_out, e_dout);
    @(posedge clk);
    m_pc = n_pc;
    m_halted = n_halt;
    if (n_we && n_rd != 5'd0) m_rf[n_rd] = n_val;
    #1;
  endtask

  task automatic probe_model();
    for (int n = 1; n < 32; n++) probe(5'(n), m_rf[n]);
  endtask

  function automatic logic [31:0] gen_ins();
    logic [31:0] r;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [11:0] imm;
    logic [2:0]  br_f3 [6];
    logic [2:0]  ld_f3 [5];
    br_f3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    r   = $urandom;
    rd  = 5'($urandom_range(0, 15));
    rs1 = 5'($urandom_range(0, 15));
    rs2 = 5'($urandom_range(0, 15));
    f3  = 3'($urandom_range(0, 7));
    imm = r[11:0];
    case ($urandom_range(0, 11))
      0:  return enc_u(r[19:0], rd, 7'h37);
      1:  return enc_u(r[19:0], rd, 7'h17);
      2:  return enc_j({r[20:1], 1'b0}, rd);
      3:  return enc_i(imm, rs1, 3'd0, rd, 7'h67);
      4:  return enc_b({r[12:1], 1'b0}, rs2, rs1, br_f3[$urandom_range(0, 5)]);
      5:  return enc_i(imm, rs1, ld_f3[$urandom_range(0, 4)], rd, 7'h03);
      6:  return enc_s(imm, rs2, rs1, 3'($urandom_range(0, 2)));
      7, 8: begin
        if (f3 == 3'd1) imm[11:5] = 7'h00;
        if (f3 == 3'd5) imm[11:5] = r[12] ? 7'h20 : 7'h00;
        return enc_i(imm, rs1, f3, rd, 7'h13);
      end
      9, 10: return enc_r(((f3 == 3'd0 || f3 == 3'd5) && r[13]) ? 7'h20 : 7'h00,
                          rs2, rs1, f3, rd, 7'h33);
      default: return r[0] ? enc_i(12'h0, 5'd0, 3'd0, 5'd0, 7'h0F) : 32'h0000_0073;
    endcase
  endfunction

  typedef struct {
    logic [31:0] ins;
    logic [31:0] din;
    logic [31:0] exp_addr;
    logic [2:0]  exp_mts;
    logic        exp_mw;
    logic [31:0] exp_dout;
    logic        chk_dout;
    logic [4:0]  reg_n;
    logic [31:0] reg_v;
    logic [31:0] exp_pa;
  } vec_t;

  vec_t tv [20];

  initial begin
    tv[0]  = '{enc_i(12'hFFB, 5'd0, 3'd0, 5'd1, 7'h13), 0, 32'hFFFF_FFFB, 3'd2, 0, 0, 0, 5'd1, 32'hFFFF_FFFB, 1};
    tv[1]  = '{enc_i(12'h003, 5'd0, 3'd0, 5'd2, 7'h13), 0, 32'h3, 3'd2, 0, 0, 0, 5'd2, 32'h3, 2};
    tv[2]  = '{enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33), 0, 32'hFFFF_FFF8, 3'd2, 0, 0, 0, 5'd3, 32'hFFFF_FFF8, 3};
    tv[3]  = '{enc_i(12'h401, 5'd1, 3'd5, 5'd4, 7'h13), 0, 32'hFFFF_FFFD, 3'd2, 0, 0, 0, 5'd4, 32'hFFFF_FFFD, 4};
    tv[4]  = '{enc_r(7'h00, 5'd1, 5'd2, 3'd3, 5'd5, 7'h33), 0, 32'h1, 3'd2, 0, 0, 0, 5'd5, 32'h1, 5};
    tv[5]  = '{enc_i(12'h007, 5'd0, 3'd0, 5'd0, 7'h13), 0, 32'h7, 3'd2, 0, 0, 0, 5'd0, 32'h0, 6};
    tv[6]  = '{enc_u(20'hABCDE, 5'd6, 7'h37), 0, 32'hABCD_E000, 3'd2, 0, 0, 0, 5'd6, 32'hABCD_E000, 7};
    tv[7]  = '{enc_i(12'h000, 5'd0, 3'd0, 5'd0, 7'h13), 0, 32'h0, 3'd2, 0, 0, 0, 5'd0, 32'h0, 8};
    tv[8]  = '{enc_u(20'h00001, 5'd7, 7'h17), 0, 32'h1020, 3'd2, 0, 0, 0, 5'd7, 32'h1020, 9};
    tv[9]  = '{enc_i(12'h100, 5'd0, 3'd0, 5'd1, 7'h13), 0, 32'h100, 3'd2, 0, 0, 0, 5'd1, 32'h100, 10};
    tv[10] = '{enc_u(20'h12345, 5'd2, 7'h37), 0, 32'h1234_5000, 3'd2, 0, 0, 0, 5'd2, 32'h1234_5000, 11};
    tv[11] = '{enc_i(12'h678, 5'd2, 3'd0, 5'd2, 7'h13), 0, 32'h1234_5678, 3'd2, 0, 0, 0, 5'd2, 32'h1234_5678, 12};
    tv[12] = '{enc_s(12'h004, 5'd2, 5'd1, 3'd2), 0, 32'h104, 3'd2, 1, 32'h1234_5678, 1, 5'd2, 32'h1234_5678, 13};
    tv[13] = '{enc_i(12'h004, 5'd1, 3'd4, 5'd3, 7'h03), 32'h78, 32'h104, 3'd4, 0, 0, 0, 5'd3, 32'h78, 14};
    tv[14] = '{enc_s(12'hFFF, 5'd3, 5'd1, 3'd0), 0, 32'hFF, 3'd0, 1, 32'h78, 1, 5'd3, 32'h78, 15};
    tv[15] = '{enc_i(12'h002, 5'd1, 3'd1, 5'd8, 7'h03), 32'hFFFF_8001, 32'h102, 3'd1, 0, 0, 0, 5'd8, 32'hFFFF_8001, 16};
    tv[16] = '{enc_r(7'h00, 5'd1, 5'd4, 3'd2, 5'd9, 7'h33), 0, 32'h1, 3'd2, 0, 0, 0, 5'd9, 32'h1, 17};
    tv[17] = '{enc_r(7'h00, 5'd5, 5'd4, 3'd5, 5'd10, 7'h33), 0, 32'h7FFF_FFFE, 3'd2, 0, 0, 0, 5'd10, 32'h7FFF_FFFE, 18};
    tv[18] = '{enc_i(12'h004, 5'd2, 3'd1, 5'd11, 7'h13), 0, 32'h2345_6780, 3'd2, 0, 0, 0, 5'd11, 32'h2345_6780, 19};
    tv[19] = '{enc_i(12'hFFF, 5'd2, 3'd4, 5'd12, 7'h13), 0, 32'hEDCB_A987, 3'd2, 0, 0, 0, 5'd12, 32'hEDCB_A987, 20};

    // Reset held for 4 cycles with a store on the bus.
    reset = 1'b0;
    instruction = enc_s(12'h000, 5'd0, 5'd0, 3'd2);
    Data_in = 32'h0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("rst%0d_pc_addr", c), PC_Addr, 32'h0);
      chk($sformatf("rst%0d_mem_write", c), {31'h0, Mem_write}, 32'h0);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rel_pc_addr", PC_Addr, 32'h0);
    for (int n = 1; n < 32; n++) probe(5'(n), 32'h0);
    instruction = enc_i(12'h000, 5'd0, 3'd0, 5'd0, 7'h13);
    #1;
    chk("rel_mem_write", {31'h0, Mem_write}, 32'h0);
    @(posedge clk);
    #1;
    chk("rel_next_pc_addr", PC_Addr, 32'h1);

    // Directed vector table, starting at PC 0.
    pulse_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      instruction = tv[i].ins;
      Data_in = tv[i].din;
      #1;
      chk($sformatf("v%0d_addr", i), Addr_out, tv[i].exp_addr);
      chk($sformatf("v%0d_mem_type", i), {29'h0, Mem_type_sel}, {29'h0, tv[i].exp_mts});
      chk($sformatf("v%0d_mem_write", i), {31'h0, Mem_write}, {31'h0, tv[i].exp_mw});
      if (tv[i].chk_dout) chk($sformatf("v%0d_dout", i), Data_out, tv[i].exp_dout);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_pc_addr", i), PC_Addr, tv[i].exp_pa);
      probe(tv[i].reg_n, tv[i].reg_v);
    end

    // Branch / jump sequence.
    pulse_reset();
    hstep(enc_b(13'd8, 5'd0, 5'd0, 3'd0));
    chk("beq_pc_addr", PC_Addr, 32'h2);
    hstep(enc_j(21'd16, 5'd1));
    chk("jal_pc_addr", PC_Addr, 32'h6);
    probe(5'd1, 32'd12);
    hstep(enc_i(12'h000, 5'd1, 3'd0, 5'd0, 7'h67));
    chk("jalr_pc_addr", PC_Addr, 32'h3);
    hstep(enc_b(13'd8, 5'd0, 5'd0, 3'd1));
    chk("bne_nt_pc_addr", PC_Addr, 32'h4);

    // Illegal opcode.
    hstep(32'h0000_007F);
`ifdef HALT_ON_ILLEGAL_EN
    chk("ill_pc_addr", PC_Addr, 32'h4);
    hstep(enc_i(12'h005, 5'd0, 3'd0, 5'd13, 7'h13));
    chk("ill_hold_pc_addr", PC_Addr, 32'h4);
    probe(5'd13, 32'h0);
`else
    chk("ill_pc_addr", PC_Addr, 32'h5);
    hstep(enc_i(12'h005, 5'd0, 3'd0, 5'd13, 7'h13));
    chk("ill_next_pc_addr", PC_Addr, 32'h6);
    probe(5'd13, 32'h5);
`endif

    // Reset asserted mid-cycle with a store in flight.
    @(negedge clk);
    instruction = enc_s(12'h000, 5'd1, 5'd0, 3'd2);
    #10 reset = 1'b0;
    #1;
    chk("mid_rst_pc_addr", PC_Addr, 32'h0);
    chk("mid_rst_mem_write", {31'h0, Mem_write}, 32'h0);
    probe(5'd1, 32'h0);
    probe(5'd13, 32'h0);
    #5 reset = 1'b1;
    instruction = enc_i(12'h000, 5'd0, 3'd0, 5'd0, 7'h13);
    #1;
    chk("mid_rel_pc_addr", PC_Addr, 32'h0);
    @(posedge clk);
    #1;
    chk("mid_rel_next_pc_addr", PC_Addr, 32'h1);

    // Random instructions against the reference model.
    pulse_reset();
    model_reset();
    for (int k = 0; k < 400; k++) begin
      rstep(k, gen_ins(), $urandom);
      if ((k % 50) == 49) probe_model();
    end
    probe_model();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
